mult_accumulator: RTL and testbench

MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

---
 rtl/mult_accumulator.sv | 129 ++++++++++++
 tb/tb_mult_accumulator.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mult_accumulator.sv
// mult_accumulator
// Sums a framed stream of unsigned multiplier products and presents the
// per-frame result through a valid/ready handshake.
//
// State table
//   ACC  | accepting beats into the running sum (in_ready=1, out_valid=0)
//   HOLD | frame result presented, waiting for out_ready (in_ready=0)
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   in_valid   product beat present on in_data
//   in_ready   block accepts a beat this cycle
//   in_data    unsigned product (PW bits), zero-extended to AW
//   in_last    beat closes the current frame
//   out_valid  frame result available
//   out_ready  downstream accepts the result
//   out_sum    saturating frame sum (AW bits)
//   out_count  beats in frame, saturating at 255
//   out_ovf    frame sum saturated
module mult_accumulator #(
    parameter int PW = 8,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic [7:0]    out_count,
    output logic          out_ovf
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [AW-1:0] r_acc;
    logic [7:0]    r_cnt;
    logic          r_ovf;
    logic [AW-1:0] r_out_sum;
    logic [7:0]    r_out_count;
    logic          r_out_ovf;

    logic          w_xfer;
    logic [AW:0]   w_sum_wide;
    logic          w_carry;
    logic [AW-1:0] w_acc_next;
    logic [7:0]    w_cnt_next;
    logic          w_ovf_next;

    // One extra bit catches the carry out of the AW-bit accumulator.
    assign w_sum_wide = {1'b0, r_acc} + {{(AW-PW+1){1'b0}}, in_data};
    assign w_carry    = w_sum_wide[AW];
    assign w_acc_next = w_carry ? {AW{1'b1}} : w_sum_wide[AW-1:0];
    assign w_cnt_next = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
    assign w_ovf_next = r_ovf | w_carry;
    assign w_xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ACC;
                end
            end
            default: begin
                w_state_next = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_xfer) begin
            if (in_last) begin
                // Result captures the closing beat; running state clears
                // so the next frame starts from zero.
                r_out_sum   <= w_acc_next;
                r_out_count <= w_cnt_next;
                r_out_ovf   <= w_ovf_next;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_ovf       <= 1'b0;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                r_ovf <= w_ovf_next;
            end
        end
    end

    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mult_accumulator.sv
// tb_mult_accumulator
// Directed bench for mult_accumulator with hand-computed expectations.
module tb_mult_accumulator;

    localparam int PW = 8;
    localparam int AW = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [7:0]    out_count;
    logic          out_ovf;

    int checks;
    int errors;

    mult_accumulator #(.PW(PW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat for one cycle; back-to-back calls give full throughput.
    task automatic send(input logic [PW-1:0] d, input logic l);
        chk("ready_before_beat", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int s, input int c, input int o);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_sum"},   32'(out_sum), 32'(s));
        chk({tag, "_count"}, 32'(out_count), 32'(c));
        chk({tag, "_ovf"},   32'(out_ovf), 32'(o));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_sum",       32'(out_sum), 32'd0);
        chk("rst_count",     32'(out_count), 32'd0);
        chk("rst_ovf",       32'(out_ovf), 32'd0);

        // 6 + 45 + 225 = 276, one bubble
        send(8'd6, 1'b0);
        send(8'd45, 1'b0);
        send(8'd225, 1'b1);
        chk_result("f276", 276, 3, 0);
        tick();
        chk("f276_bubble_ready", 32'(in_ready), 32'd1);
        chk("f276_after_valid",  32'(out_valid), 32'd0);
        chk("f276_retained_sum", 32'(out_sum), 32'd276);

        // single-beat frame
        send(8'd121, 1'b1);
        chk_result("single", 121, 1, 0);
        tick();

        // 258 x 255 = 65790 saturates to 65535, count saturates at 255
        for (int i = 1; i <= 258; i++) begin
            send(8'd255, (i == 258));
        end
        chk_result("sat", 65535, 255, 1);
        tick();
        send(8'd10, 1'b1);
        chk_result("post_sat", 10, 1, 0);
        tick();

        // backpressure: result held 5 cycles, offered beats ignored
        out_ready = 1'b0;
        send(8'd1, 1'b0);
        send(8'd2, 1'b1);
        chk_result("bp_enter", 3, 2, 0);
        in_valid = 1'b1;
        in_data  = 8'd99;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_sum",   32'(out_sum), 32'd3);
            chk("bp_hold_count", 32'(out_count), 32'd2);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        send(8'd5, 1'b1);
        chk_result("bp_next", 5, 1, 0);
        tick();

        // reset mid-frame, coinciding with an offered last beat
        send(8'd100, 1'b0);
        send(8'd50, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd77;
        in_last  = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_sum",   32'(out_sum), 32'd0);
        out_ready = 1'b0;
        send(8'd7, 1'b1);
        chk_result("after_rst", 7, 1, 0);

        // reset while holding a result, with out_ready raised at once
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("holdrst_valid", 32'(out_valid), 32'd0);
        chk("holdrst_ready", 32'(in_ready), 32'd1);
        chk("holdrst_sum",   32'(out_sum), 32'd0);
        chk("holdrst_count", 32'(out_count), 32'd0);
        chk("holdrst_ovf",   32'(out_ovf), 32'd0);

        // gaps with garbage data do not disturb the frame
        send(8'd9, 1'b0);
        in_data = 8'd200;
        in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_valid", 32'(out_valid), 32'd0);
            chk("gap_ready", 32'(in_ready), 32'd1);
        end
        in_last = 1'b0;
        send(8'd4, 1'b1);
        chk_result("gap", 13, 2, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
